// File: rtl/alloc_pkg.sv
// alloc_pkg
// Shared types and field helpers for the ch2 router output allocator.
//   phit_type_e   : 2-bit phit type field encoding (IDLE/TAIL/PAYLOAD/HEAD)
//   alloc_state_e : lock FSM state (IDLE/BUSY)
//   type_hi/type_lo : bit positions of the type field inside a phit of a
//                     given width (the type field sits in the top two bits)
package alloc_pkg;

    localparam int TYPE_W = 2;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_TAIL    = 2'b01,
        PH_PAYLOAD = 2'b10,
        PH_HEAD    = 2'b11
    } phit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alloc_state_e;

    function automatic int type_hi(input int phit_w);
        return phit_w - 1;
    endfunction

    function automatic int type_lo(input int phit_w);
        return phit_w - TYPE_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr and walks
// upward with wrap-around; the first set request wins. The pointer register
// is owned by the parent, which advances it past the winner.
// Ports:
//   req [N-1:0]  request vector
//   ptr [W-1:0]  first index to consider (must be < N)
//   en           arbitration enable; gnt/idx are zero when low
//   gnt [N-1:0]  one-hot grant (or zero)
//   idx [W-1:0]  encoded index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            // Rotated position, wrapped modulo N without a divider.
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (en && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = W'(pos);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_output_allocator.sv
// rr_output_allocator
// Per-output-port allocator for the ch2 router. Head phits addressed to this
// port are arbitrated round-robin; the winner then owns the port until its
// packet ends. Optional macro ALLOC_TAIL_EN makes a TAIL phit on the owner
// the explicit last phit of a packet.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   this_port  index of the output port served by this instance
//   in_phit    flattened input phits, input i at [i*PHIT_W +: PHIT_W]
//   out_ready  downstream accepts a phit this cycle
//   select     one-hot (or zero) crossbar select, combinational
//   shift      pulses when a new head is granted this cycle
//   busy       registered, port locked to an owner
//   owner      registered index of the current/last owner
module rr_output_allocator
    import alloc_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int PORT_W = $clog2(NUM_IN),
    parameter int PHIT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORT_W-1:0]        this_port,
    input  logic [NUM_IN*PHIT_W-1:0] in_phit,
    input  logic                     out_ready,
    output logic [NUM_IN-1:0]        select,
    output logic                     shift,
    output logic                     busy,
    output logic [PORT_W-1:0]        owner
);

    localparam int TYPE_LO = type_lo(PHIT_W);
    localparam int MID_W   = TYPE_LO - PORT_W;

    phit_type_e        ph_type [NUM_IN];
    logic [NUM_IN-1:0] request;

    alloc_state_e      state_q, state_d;
    logic [PORT_W-1:0] owner_q, owner_d;
    logic [PORT_W-1:0] ptr_q, ptr_d;

    phit_type_e        owner_type;
    logic              pkt_cont;
    logic              tail_end;
    logic              arb_en;
    logic [NUM_IN-1:0] grant;
    logic [PORT_W-1:0] grant_idx;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign ph_type[i] = phit_type_e'(in_phit[i*PHIT_W + TYPE_LO +: TYPE_W]);
        assign request[i] = (ph_type[i] == PH_HEAD) &&
                            (in_phit[i*PHIT_W +: PORT_W] == this_port);
        // Payload bits between dest and type do not affect allocation.
        if (MID_W > 0) begin : g_mid
            logic unused_mid;
            assign unused_mid = ^in_phit[i*PHIT_W + PORT_W +: MID_W];
        end
    end

    assign owner_type = ph_type[owner_q];

    // The lock holds while the owner keeps streaming the body of its packet;
    // any other phit type on the owner releases the port in the same cycle.
`ifdef ALLOC_TAIL_EN
    assign pkt_cont = (state_q == ST_BUSY) &&
                      (owner_type == PH_PAYLOAD || owner_type == PH_TAIL);
    assign tail_end = pkt_cont && (owner_type == PH_TAIL);
`else
    assign pkt_cont = (state_q == ST_BUSY) && (owner_type == PH_PAYLOAD);
    assign tail_end = 1'b0;
`endif

    assign arb_en = out_ready && !pkt_cont;

    rr_arbiter #(
        .N (NUM_IN),
        .W (PORT_W)
    ) u_arb (
        .req (request),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (grant),
        .idx (grant_idx)
    );

    assign select = pkt_cont ? (NUM_IN'(1) << owner_q) : grant;
    assign shift  = |grant;
    assign busy   = (state_q == ST_BUSY);
    assign owner  = owner_q;

    // Everything freezes under backpressure. A grant wins over the release
    // path, so a packet ending and a new head starting share one cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (out_ready) begin
            if (|grant) begin
                state_d = ST_BUSY;
                owner_d = grant_idx;
                ptr_d   = (grant_idx == PORT_W'(NUM_IN - 1)) ? '0
                                                              : grant_idx + PORT_W'(1);
            end else if (pkt_cont && !tail_end) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
